search_sched: RTL and testbench

SEARCH_SCHED -- requirements
Module: search_sched

---
 rtl/search_sched.sv | 167 ++++++++++++++++
 tb/tb_search_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_sched.sv
// rtl/search_sched.sv - round-robin job scheduler in front of a single pattern-search engine
module search_sched #(
    parameter logic [19:0] TIMEOUT   = 20'd1000000,
    parameter logic [14:0] NOT_FOUND = 15'h00FF
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [1:0]  req,
    input  logic [15:0] p_in,
    input  logic [15:0] pl_in,
    input  logic [15:0] b_in,
    input  logic [29:0] bl_in,
    output logic [1:0]  ack,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [14:0] rsp_found,
    output logic        rsp_hit,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [7:0]  eng_p,
    output logic [7:0]  eng_pl,
    output logic [7:0]  eng_b,
    output logic [14:0] eng_bl,
    output logic        eng_activate,
    output logic        eng_reset,
    input  logic        eng_done,
    input  logic [14:0] eng_found
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  p_q, p_d, pl_q, pl_d, b_q, b_d;
    logic [14:0] bl_q, bl_d;
    logic [19:0] timer_q, timer_d;
    logic [14:0] found_q, found_d;
    logic        hit_q, hit_d;
    logic        tmo_q, tmo_d;
    logic [1:0]  valid_q, valid_d;

    logic        gnt;
    logic [7:0]  sel_p, sel_pl, sel_b;
    logic [14:0] sel_bl;
    logic        degen;

    // A tie goes to whichever requester was not granted last.
    always_comb begin
        gnt    = (req == 2'b11) ? ~last_q : req[1];
        sel_p  = gnt ? p_in[15:8]   : p_in[7:0];
        sel_pl = gnt ? pl_in[15:8]  : pl_in[7:0];
        sel_b  = gnt ? b_in[15:8]   : b_in[7:0];
        sel_bl = gnt ? bl_in[29:15] : bl_in[14:0];
        degen  = (sel_pl == 8'd0) || (sel_bl == 15'd0) || ({7'd0, sel_pl} > sel_bl);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        p_d     = p_q;
        pl_d    = pl_q;
        b_d     = b_q;
        bl_d    = bl_q;
        timer_d = timer_q;
        found_d = found_q;
        hit_d   = hit_q;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    p_d     = sel_p;
                    pl_d    = sel_pl;
                    b_d     = sel_b;
                    bl_d    = sel_bl;
                    if (degen) begin
                        found_d = NOT_FOUND;
                        hit_d   = 1'b0;
                        tmo_d   = 1'b0;
                        valid_d = {gnt, ~gnt};
                        state_d = RESP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                timer_d = 20'd0;
                state_d = RUN;
            end
            RUN: begin
                // A done seen on the final timer cycle still counts as a completion.
                if (eng_done) begin
                    found_d = eng_found;
                    hit_d   = (eng_found != NOT_FOUND);
                    tmo_d   = 1'b0;
                    valid_d = {owner_q, ~owner_q};
                    state_d = RESP;
                end else if (timer_q == TIMEOUT - 20'd1) begin
                    found_d = NOT_FOUND;
                    hit_d   = 1'b0;
                    tmo_d   = 1'b1;
                    valid_d = {owner_q, ~owner_q};
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    valid_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            p_q     <= 8'd0;
            pl_q    <= 8'd0;
            b_q     <= 8'd0;
            bl_q    <= 15'd0;
            timer_q <= 20'd0;
            found_q <= NOT_FOUND;
            hit_q   <= 1'b0;
            tmo_q   <= 1'b0;
            valid_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            p_q     <= p_d;
            pl_q    <= pl_d;
            b_q     <= b_d;
            bl_q    <= bl_d;
            timer_q <= timer_d;
            found_q <= found_d;
            hit_q   <= hit_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
        end
    end

    // The accept pulse marks the IDLE cycle itself so the requester can drop req after the edge.
    assign ack          = (state_q == IDLE && CPU_RESETN && |req) ? {gnt, ~gnt} : 2'b00;
    assign busy         = (state_q != IDLE);
    assign eng_activate = (state_q == RUN);
    assign eng_reset    = (state_q != RUN);
    assign eng_p        = p_q;
    assign eng_pl       = pl_q;
    assign eng_b        = b_q;
    assign eng_bl       = bl_q;
    assign rsp_valid    = valid_q;
    assign rsp_found    = found_q;
    assign rsp_hit      = hit_q;
    assign rsp_timeout  = tmo_q;

endmodule

// File: tb/tb_search_sched.sv
// tb/tb_search_sched.sv - table, hand-sequence and random checks of search_sched against a job-level model
module tb_search_sched;

    localparam int          TMO = 16;
    localparam logic [14:0] NF  = 15'h00FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req = 2'b00;
    logic [15:0] p_in = '0, pl_in = '0, b_in = '0;
    logic [29:0] bl_in = '0;
    logic [1:0]  ack, rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [14:0] rsp_found;
    logic        rsp_hit, rsp_timeout, busy;
    logic [7:0]  eng_p, eng_pl, eng_b;
    logic [14:0] eng_bl;
    logic        eng_activate, eng_reset;
    logic        eng_done = 1'b0;
    logic [14:0] eng_found = '0;

    search_sched #(.TIMEOUT(20'd16), .NOT_FOUND(NF)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .req(req),
        .p_in(p_in), .pl_in(pl_in), .b_in(b_in), .bl_in(bl_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_found(rsp_found), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout), .busy(busy),
        .eng_p(eng_p), .eng_pl(eng_pl), .eng_b(eng_b), .eng_bl(eng_bl),
        .eng_activate(eng_activate), .eng_reset(eng_reset),
        .eng_done(eng_done), .eng_found(eng_found)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int model_last = 1;

    // Engine stand-in: raises a sticky done after eng_lat_cfg active cycles (0 = never).
    int          eng_cnt = 0;
    int          eng_lat_cfg = 0;
    logic [14:0] eng_res_cfg = '0;
    always @(negedge clk) begin
        if (eng_reset) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end else if (eng_activate) begin
            eng_cnt = eng_cnt + 1;
            if (eng_lat_cfg != 0 && eng_cnt >= eng_lat_cfg) begin
                eng_done  = 1'b1;
                eng_found = eng_res_cfg;
            end
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [15:0] p, pl, b;
        logic [29:0] bl;
        int          lat;
        logic [14:0] res;
        int          hold;
        int          e_owner;
        logic [14:0] e_found;
        logic        e_hit, e_tmo;
        int          e_act;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rq,
                                input logic [7:0] p0, input logic [7:0] pl0, input logic [7:0] b0, input logic [14:0] bl0,
                                input logic [7:0] p1, input logic [7:0] pl1, input logic [7:0] b1, input logic [14:0] bl1,
                                input int lat, input logic [14:0] res, input int hold,
                                input int eo, input logic [14:0] ef, input logic eh, input logic et, input int ea);
        vec_t v;
        v.req = rq; v.p = {p1, p0}; v.pl = {pl1, pl0}; v.b = {b1, b0}; v.bl = {bl1, bl0};
        v.lat = lat; v.res = res; v.hold = hold;
        v.e_owner = eo; v.e_found = ef; v.e_hit = eh; v.e_tmo = et; v.e_act = ea;
        return v;
    endfunction

    // Job-level reference: who wins, whether the job is degenerate, and how it ends.
    function automatic vec_t predict(input vec_t v, input int last);
        int o, pl, bl;
        o  = (v.req == 2'b11) ? ((last == 1) ? 0 : 1) : (v.req[1] ? 1 : 0);
        pl = (o == 1) ? int'(v.pl[15:8]) : int'(v.pl[7:0]);
        bl = (o == 1) ? int'(v.bl[29:15]) : int'(v.bl[14:0]);
        v.e_owner = o;
        if (pl == 0 || bl == 0 || pl > bl) begin
            v.e_found = NF; v.e_hit = 1'b0; v.e_tmo = 1'b0; v.e_act = 0;
        end else if (v.lat >= 1 && v.lat <= TMO) begin
            v.e_found = v.res; v.e_hit = (v.res != NF); v.e_tmo = 1'b0; v.e_act = v.lat;
        end else begin
            v.e_found = NF; v.e_hit = 1'b0; v.e_tmo = 1'b1; v.e_act = TMO;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0]  oh;
        logic [7:0]  xp;
        logic [14:0] xbl;
        int          first, act, n;
        bit          bad_ack, unstable, got;
        req = v.req; p_in = v.p; pl_in = v.pl; b_in = v.b; bl_in = v.bl;
        eng_lat_cfg = v.lat; eng_res_cfg = v.res;
        #1;
        n = 0;
        while (ack == 2'b00 && n < 20) begin
            @(negedge clk);
            req = v.req;
            #1;
            n++;
        end
        oh  = (v.e_owner == 1) ? 2'b10 : 2'b01;
        xp  = (v.e_owner == 1) ? v.p[15:8] : v.p[7:0];
        xbl = (v.e_owner == 1) ? v.bl[29:15] : v.bl[14:0];
        chk($sformatf("%s.ack", tag), 32'(ack), 32'(oh));
        model_last = v.e_owner;
        first = -1; act = 0; bad_ack = 0; got = 0;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk);
            if (ack != 2'b00) bad_ack = 1;
            if (k == 1) begin
                req = 2'($urandom); p_in = 16'($urandom); pl_in = 16'($urandom);
                b_in = 16'($urandom); bl_in = 30'($urandom);
            end
            if (eng_activate) begin
                act++;
                if (first < 0) first = k;
            end
            if (rsp_valid != 2'b00) got = 1;
        end
        chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(oh));
        chk($sformatf("%s.found", tag), 32'(rsp_found), 32'(v.e_found));
        chk($sformatf("%s.hit", tag), 32'(rsp_hit), 32'(v.e_hit));
        chk($sformatf("%s.timeout", tag), 32'(rsp_timeout), 32'(v.e_tmo));
        chk($sformatf("%s.act_cycles", tag), 32'(act), 32'(v.e_act));
        chk($sformatf("%s.first_act", tag), 32'(first), (v.e_act > 0) ? 32'd2 : 32'hFFFF_FFFF);
        chk($sformatf("%s.ack_while_busy", tag), 32'(bad_ack), 32'd0);
        chk($sformatf("%s.eng_reset_resp", tag), 32'(eng_reset), 32'd1);
        chk($sformatf("%s.eng_p", tag), 32'(eng_p), 32'(xp));
        chk($sformatf("%s.eng_bl", tag), 32'(eng_bl), 32'(xbl));
        if (v.hold > 0) begin
            rsp_ready = ~oh;
            unstable = 0;
            repeat (v.hold) begin
                @(negedge clk);
                if (rsp_valid !== oh || rsp_found !== v.e_found || rsp_hit !== v.e_hit ||
                    rsp_timeout !== v.e_tmo || eng_activate !== 1'b0 || busy !== 1'b1)
                    unstable = 1;
            end
            chk($sformatf("%s.hold_stable", tag), 32'(unstable), 32'd0);
        end
        rsp_ready = oh;
        @(negedge clk);
        chk($sformatf("%s.valid_cleared", tag), 32'(rsp_valid), 32'd0);
        chk($sformatf("%s.idle_after", tag), 32'(busy), 32'd0);
        rsp_ready = 2'b00;
        if (busy) begin
            rsp_ready = 2'b11;
            @(negedge clk);
            rsp_ready = 2'b00;
        end
    endtask

    vec_t tab_a[$];
    vec_t tab_b[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        bit   bad;

        //         req   p0 pl0 b0  bl0    p1     pl1 b1     bl1  lat res    hold own found  h  t  act
        tab_a.push_back(mk(2'b01, 3, 4, 0, 250, 0, 0, 0, 0, 5, 15'd17, 50, 0, 15'd17, 1, 0, 5));
        tab_a.push_back(mk(2'b10, 0, 0, 0, 0, 8'h21, 2, 8'h40, 10, 3, NF, 2, 1, NF, 0, 0, 3));
        tab_a.push_back(mk(2'b01, 7, 0, 9, 100, 0, 0, 0, 0, 2, 15'd5, 1, 0, NF, 0, 0, 0));
        tab_a.push_back(mk(2'b01, 7, 9, 9, 5, 0, 0, 0, 0, 2, 15'd5, 0, 0, NF, 0, 0, 0));
        tab_a.push_back(mk(2'b10, 0, 0, 0, 0, 8'h55, 5, 8'h66, 5, 1, 15'd0, 0, 1, 15'd0, 1, 0, 1));
        tab_a.push_back(mk(2'b10, 0, 0, 0, 0, 8'h11, 1, 8'h22, 0, 1, 15'd3, 1, 1, NF, 0, 0, 0));
        tab_a.push_back(mk(2'b01, 8'h80, 4, 1, 250, 0, 0, 0, 0, 0, 15'd9, 3, 0, NF, 0, 1, 16));
        tab_a.push_back(mk(2'b01, 8'h81, 4, 1, 250, 0, 0, 0, 0, 16, 15'd42, 0, 0, 15'd42, 1, 0, 16));
        tab_a.push_back(mk(2'b01, 8'h82, 4, 1, 250, 0, 0, 0, 0, 17, 15'd42, 0, 0, NF, 0, 1, 16));
        tab_b.push_back(mk(2'b11, 1, 3, 2, 40, 5, 6, 7, 60, 2, 15'd100, 0, 0, 15'd100, 1, 0, 2));
        tab_b.push_back(mk(2'b11, 1, 3, 2, 40, 5, 6, 7, 60, 4, 15'd200, 1, 1, 15'd200, 1, 0, 4));
        tab_b.push_back(mk(2'b11, 1, 3, 2, 40, 5, 6, 7, 60, 1, NF, 0, 0, NF, 0, 0, 1));
        tab_b.push_back(mk(2'b11, 1, 3, 2, 40, 5, 6, 7, 60, 3, 15'd7, 2, 1, 15'd7, 1, 0, 3));

        rst_n = 1'b0;
        req = 2'b11;
        repeat (2) @(negedge clk);
        chk("reset.ack", 32'(ack), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.found", 32'(rsp_found), 32'(NF));
        chk("reset.hit_tmo", 32'({rsp_hit, rsp_timeout}), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.eng_ctl", 32'({eng_activate, eng_reset}), 32'd1);
        chk("reset.eng_fields", 32'({eng_p, eng_pl, eng_b}), 32'd0);
        chk("reset.eng_bl", 32'(eng_bl), 32'd0);
        req = 2'b00;
        rst_n = 1'b1;

        foreach (tab_a[i]) run_vec(tab_a[i], $sformatf("tabA%0d", i));

        // Reset pulse in the middle of a RUN phase.
        v = mk(2'b01, 4, 4, 4, 300, 0, 0, 0, 0, 0, 15'd1, 0, 0, NF, 0, 1, 16);
        req = v.req; p_in = v.p; pl_in = v.pl; b_in = v.b; bl_in = v.bl;
        eng_lat_cfg = 0;
        #1;
        chk("midrst.ack", 32'(ack), 32'd1);
        n = 0;
        @(negedge clk);
        req = 2'b00;
        while (!eng_activate && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.in_run", 32'(eng_activate), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.eng_activate", 32'(eng_activate), 32'd0);
        chk("midrst.eng_reset", 32'(eng_reset), 32'd1);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.found", 32'(rsp_found), 32'(NF));
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || ack != 2'b00) bad = 1;
        end
        chk("midrst.no_rsp", 32'(bad), 32'd0);
        rst_n = 1'b1;
        model_last = 1;

        foreach (tab_b[i]) run_vec(tab_b[i], $sformatf("rr%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.req  = 2'($urandom_range(1, 3));
            v.p    = 16'($urandom);
            v.pl   = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
            v.b    = 16'($urandom);
            v.bl   = {15'($urandom_range(0, 20)), 15'($urandom_range(0, 20))};
            v.lat  = $urandom_range(0, 20);
            v.res  = ($urandom_range(0, 3) == 0) ? NF : 15'($urandom);
            v.hold = $urandom_range(0, 3);
            v = predict(v, model_last);
            run_vec(v, $sformatf("rnd%0d", i));
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
